// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N radix-2 shift-and-add multiplier, one step per clock.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module N_bit_adder #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  logic [N:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (c[i] & (a[i] ^ b[i]));
  end

endmodule

module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mcand_d;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_d;
  logic [N-1:0]  mq;
  logic [N-1:0]  mq_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [N:0]    addend;
  logic [N:0]    sum;
  logic          accept;
  logic          last;
  logic          zero_op;

  // One extra adder bit keeps the carry so acc never overflows.
  assign addend = mq[0] ? {1'b0, mcand} : '0;

  N_bit_adder #(
    .N(N + 1)
  ) u_add (
    .a   ({1'b0, acc}),
    .b   (addend),
    .sum (sum)
  );

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(N - 1));

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (multiplicand == '0)
                || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_d = state;
    mcand_d = mcand;
    acc_d   = acc;
    mq_d    = mq;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          mcand_d = multiplicand;
          acc_d   = '0;
          cnt_d   = '0;
          mq_d    = zero_op ? '0 : multiplier;
          state_d = zero_op ? DONE : BUSY;
        end
      end
      BUSY: begin
        acc_d = sum[N:1];
        mq_d  = {sum[0], mq[N-1:1]};
        cnt_d = cnt + 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      mcand <= mcand_d;
      acc   <= acc_d;
      mq    <= mq_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == BUSY);
    out_valid = (state == DONE);
    product   = {acc, mq};
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with a queue of expected products.
module tb_shift_add_multiplier;

  localparam int N = 32;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  int checks;
  int failures;
  logic [2*N-1:0] exp_q[$];

  shift_add_multiplier #(
    .N(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_prod(input string tag);
    logic [2*N-1:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    check(tag, product, e);
  endtask

  task automatic send(input string tag,
                      input logic [N-1:0] a,
                      input logic [N-1:0] b,
                      input logic exp_busy);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    exp_q.push_back({32'd0, a} * {32'd0, b});
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, exp_busy);
  endtask

  task automatic wait_out(input string tag, input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check_prod({tag, "_product"});
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_low"}, out_valid, 1'b0);
    check({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  logic [2*N-1:0] dropped;
  logic           acc_now;
  int             pidx;
  int             nout;
  int             last_c;
  logic [N-1:0]   a6[3];
  logic [N-1:0]   b6[3];

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;
    tick();

    // 1: basic product and latency
    send("t1", 32'd100, 32'd200, 1'b1);
    wait_out("t1", N);
    consume("t1");

    // 2: full-scale operands, carry retained
    send("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_out("t2", N);
    consume("t2");

    // 3: backpressure, new offers ignored while DONE
    send("t3", 32'd7, 32'd9, 1'b1);
    wait_out("t3", N);
    multiplicand = 32'd1;
    multiplier   = 32'd1;
    in_valid     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", out_valid, 1'b1);
      check("t3_hold_product", product, 64'd63);
      check("t3_hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    consume("t3");

    // 4: reset aborts an operation in flight
    send("t4", 32'd12345, 32'd678, 1'b1);
    dropped = exp_q.pop_back();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    check("t4_abort_out_valid", out_valid, 1'b0);
    check("t4_abort_busy", busy, 1'b0);
    check("t4_abort_in_ready", in_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    send("t4b", 32'd3, 32'd5, 1'b1);
    wait_out("t4b", N);
    consume("t4b");

    // 5: zero operand
`ifdef MUL_ZERO_BYPASS_EN
    send("t5", 32'd0, 32'd55, 1'b0);
    wait_out("t5", 0);
`else
    send("t5", 32'd0, 32'd55, 1'b1);
    wait_out("t5", N);
`endif
    consume("t5");

    // 6: back-to-back stream, 34 cycles per product
    a6[0] = 32'd2;         b6[0] = 32'd3;
    a6[1] = 32'h8000_0000; b6[1] = 32'd2;
    a6[2] = 32'd65535;     b6[2] = 32'd65537;
    pidx   = 0;
    nout   = 0;
    last_c = -1;
    multiplicand = a6[0];
    multiplier   = b6[0];
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    for (int c = 0; c < 300 && nout < 3; c++) begin
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) begin
        exp_q.push_back({32'd0, a6[pidx]} * {32'd0, b6[pidx]});
        pidx++;
        if (pidx < 3) begin
          multiplicand = a6[pidx];
          multiplier   = b6[pidx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check_prod("t6_product");
        if (last_c >= 0) check("t6_gap", c - last_c, 34);
        last_c = c;
        nout++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("t6_count", nout, 3);
    check("t6_expected_in_product", (64'd6 << 0), 64'd2 * 64'd3);
    tick();
    check("end_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
